mem_copy_engine: RTL

//  Initiator/master for the 8-bit data memory port (Address/WriteData/MemRead/MemWrite/ReadData).

---
 rtl/mce_pkg.sv | 9 +
 rtl/mem_copy_engine_if.sv | 29 ++
 rtl/mce_addr_gen.sv | 43 ++++
 rtl/mem_copy_engine.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mce_pkg.sv
// Shared types and default widths for the memory copy engine.
package mce_pkg;

  localparam int unsigned MCE_ADDR_W = 8;
  localparam int unsigned MCE_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} mce_state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Data memory port: Address/WriteData/MemRead/MemWrite driven by the master, ReadData returned.
interface mem_copy_engine_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_read,
    output mem_write,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_read,
    input  mem_write,
    output mem_rdata
  );

endinterface

// File: rtl/mce_addr_gen.sv
// Latched source/destination/length and byte index for the copy engine.
module mce_addr_gen #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      src_q <= src_i;
      dst_q <= dst_i;
      len_q <= len_i;
      idx_q <= '0;
    end else if (step_i) begin
      idx_q <= idx_q + ADDR_W'(1);
    end
  end

  // Read address of the next pair: consumed on the same edge that advances idx.
  assign rd_addr_o = src_q + idx_q + ADDR_W'(1);
  assign wr_addr_o = dst_q + idx_q;
  assign last_o    = ({1'b0, idx_q} + (ADDR_W + 1)'(1)) >= {1'b0, len_q};

endmodule

// File: rtl/mem_copy_engine.sv
// Byte-block copy master for the data memory port; optional running checksum with MCE_CHECKSUM_EN.
module mem_copy_engine
  import mce_pkg::*;
#(
  parameter int unsigned ADDR_W = MCE_ADDR_W,
  parameter int unsigned DATA_W = MCE_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [ADDR_W-1:0]      src_addr_i,
  input  logic [ADDR_W-1:0]      dst_addr_i,
  input  logic [ADDR_W-1:0]      length_i,
  output logic                   busy_o,
  output logic                   done_o,
`ifdef MCE_CHECKSUM_EN
  output logic [DATA_W-1:0]      checksum_o,
`endif
  mem_copy_engine_if.master      mem_io
);

  mce_state_t        state_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic              load;
  logic              step;
  logic              last;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign load = (state_q == IDLE) && start_i;
  assign step = (state_q == WRITE);

  mce_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .src_i     (src_addr_i),
    .dst_i     (dst_addr_i),
    .len_i     (length_i),
    .rd_addr_o (rd_addr),
    .wr_addr_o (wr_addr),
    .last_o    (last)
  );

  // data_q is non-zero only in WRITE, so it drives WriteData directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (length_i != '0) begin
              state_q <= READ;
              busy_q  <= 1'b1;
              rd_q    <= 1'b1;
              addr_q  <= src_addr_i;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        READ: begin
          state_q <= WRITE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b1;
          addr_q  <= wr_addr;
          data_q  <= mem_io.mem_rdata;
        end
        WRITE: begin
          wr_q   <= 1'b0;
          data_q <= '0;
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            addr_q  <= '0;
          end else begin
            state_q <= READ;
            rd_q    <= 1'b1;
            addr_q  <= rd_addr;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign mem_io.mem_read  = rd_q;
  assign mem_io.mem_write = wr_q;
  assign mem_io.mem_addr  = addr_q;
  assign mem_io.mem_wdata = data_q;

`ifdef MCE_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (load) begin
      csum_q <= '0;
    end else if (step) begin
      csum_q <= csum_q + data_q;
    end
  end

  assign checksum_o = csum_q;
`endif

endmodule
